// File: rtl/dmem_store_buffer.sv
// Speculative store buffer: circular queue of SPEC/COMMIT stores drained in order to the cache.
// Define STORE_BUFFER_BYPASS_EN to build store-to-load forwarding; otherwise bypass_o/data_rd_o are tied 0.
module dmem_store_buffer #(
    parameter int STORE_BUFFER_SIZE = 4,
    localparam int IDX_W = $clog2(STORE_BUFFER_SIZE)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [31:0]                  addr_i,
    input  logic [31:0]                  data_i,
    output logic [IDX_W-1:0]             store_buffer_idx_o,
    input  logic                         load_i,
    output logic                         bypass_o,
    output logic [31:0]                  data_rd_o,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [31:0]                  addr_o,
    output logic [31:0]                  data_wr_o,
    input  logic                         store_buffer_commit_i,
    input  logic [IDX_W-1:0]             store_buffer_idx_commit_i,
    input  logic [STORE_BUFFER_SIZE-1:0] store_buffer_discard_i
);

    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_SPEC   = 2'd1,
        SLOT_COMMIT = 2'd2
    } slot_state_e;

    slot_state_e      state_reg  [STORE_BUFFER_SIZE];
    slot_state_e      state_next [STORE_BUFFER_SIZE];
    logic [31:0]      addr_mem   [STORE_BUFFER_SIZE];
    logic [31:0]      data_mem   [STORE_BUFFER_SIZE];
    logic [IDX_W:0]   head_reg, head_next;
    logic [IDX_W:0]   tail_reg, tail_next;
    logic [IDX_W-1:0] head_idx, tail_idx;
    logic             empty, full, alloc, head_commit, pop, skip;

    assign head_idx = head_reg[IDX_W-1:0];
    assign tail_idx = tail_reg[IDX_W-1:0];
    assign empty    = (head_reg == tail_reg);
    assign full     = (head_idx == tail_idx) && (head_reg[IDX_W] != tail_reg[IDX_W]);

    assign req_ready_o        = !full;
    assign alloc              = req_valid_i && !full;
    assign store_buffer_idx_o = tail_idx;

    // Head is either a committed store waiting for the cache or a discarded hole to skip.
    assign head_commit = !empty && (state_reg[head_idx] == SLOT_COMMIT);
    assign skip        = !empty && (state_reg[head_idx] == SLOT_FREE);
    assign pop         = head_commit && rsp_ready_i;

    assign rsp_valid_o = head_commit;
    assign addr_o      = head_commit ? addr_mem[head_idx] : 32'h0;
    assign data_wr_o   = head_commit ? data_mem[head_idx] : 32'h0;

    assign head_next = (pop || skip) ? head_reg + {{IDX_W{1'b0}}, 1'b1} : head_reg;
    assign tail_next = alloc ? tail_reg + {{IDX_W{1'b0}}, 1'b1} : tail_reg;

    // Discard outranks commit; alloc only hits a FREE slot, so it never collides with either.
    always_comb begin
        for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
            state_next[i] = state_reg[i];
            if (alloc && (tail_idx == IDX_W'(i))) begin
                state_next[i] = SLOT_SPEC;
            end else if ((state_reg[i] == SLOT_SPEC) && store_buffer_discard_i[i]) begin
                state_next[i] = SLOT_FREE;
            end else if ((state_reg[i] == SLOT_SPEC) && store_buffer_commit_i &&
                         (store_buffer_idx_commit_i == IDX_W'(i))) begin
                state_next[i] = SLOT_COMMIT;
            end else if (pop && (head_idx == IDX_W'(i))) begin
                state_next[i] = SLOT_FREE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_reg <= '0;
            tail_reg <= '0;
            for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
                state_reg[i] <= SLOT_FREE;
            end
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
                state_reg[i] <= state_next[i];
            end
        end
    end

    // Payload needs no reset: it is only observed through slots marked SPEC/COMMIT.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            addr_mem[tail_idx] <= addr_i;
            data_mem[tail_idx] <= data_i;
        end
    end

`ifdef STORE_BUFFER_BYPASS_EN
    logic [STORE_BUFFER_SIZE-1:0] hit;
    logic [IDX_W-1:0]             scan_idx;

    for (genvar gi = 0; gi < STORE_BUFFER_SIZE; gi++) begin : g_hit
        assign hit[gi] = load_i && (state_reg[gi] != SLOT_FREE) && (addr_mem[gi] == addr_i);
    end

    // Scan oldest to youngest so the last hit seen is the one closest to the tail.
    always_comb begin
        bypass_o  = 1'b0;
        data_rd_o = 32'h0;
        scan_idx  = head_idx;
        for (int k = 0; k < STORE_BUFFER_SIZE; k++) begin
            scan_idx = head_idx + IDX_W'(k);
            if (hit[scan_idx]) begin
                bypass_o  = 1'b1;
                data_rd_o = data_mem[scan_idx];
            end
        end
    end
`else
    logic unused_load;
    assign unused_load = load_i;
    assign bypass_o    = 1'b0;
    assign data_rd_o   = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer (4 entries); forwarding expectations follow STORE_BUFFER_BYPASS_EN.
module tb_dmem_store_buffer;

    localparam int SIZE  = 4;
    localparam int IDX_W = 2;

`ifdef STORE_BUFFER_BYPASS_EN
    localparam logic [31:0] EXP_BYP  = 32'h1;
    localparam logic [31:0] EXP_FWD  = 32'h22;
`else
    localparam logic [31:0] EXP_BYP  = 32'h0;
    localparam logic [31:0] EXP_FWD  = 32'h0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic [31:0]      addr_i = '0;
    logic [31:0]      data_i = '0;
    logic [IDX_W-1:0] store_buffer_idx_o;
    logic             load_i = 1'b0;
    logic             bypass_o;
    logic [31:0]      data_rd_o;
    logic             rsp_valid_o;
    logic             rsp_ready_i = 1'b0;
    logic [31:0]      addr_o;
    logic [31:0]      data_wr_o;
    logic             store_buffer_commit_i = 1'b0;
    logic [IDX_W-1:0] store_buffer_idx_commit_i = '0;
    logic [SIZE-1:0]  store_buffer_discard_i = '0;

    int err_cnt = 0;
    int chk_cnt = 0;

    dmem_store_buffer #(.STORE_BUFFER_SIZE(SIZE)) dut (
        .clk_i                     (clk_i),
        .rst_i                     (rst_i),
        .req_valid_i               (req_valid_i),
        .req_ready_o               (req_ready_o),
        .addr_i                    (addr_i),
        .data_i                    (data_i),
        .store_buffer_idx_o        (store_buffer_idx_o),
        .load_i                    (load_i),
        .bypass_o                  (bypass_o),
        .data_rd_o                 (data_rd_o),
        .rsp_valid_o               (rsp_valid_o),
        .rsp_ready_i               (rsp_ready_i),
        .addr_o                    (addr_o),
        .data_wr_o                 (data_wr_o),
        .store_buffer_commit_i     (store_buffer_commit_i),
        .store_buffer_idx_commit_i (store_buffer_idx_commit_i),
        .store_buffer_discard_i    (store_buffer_discard_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_valid_i            = 1'b0;
        addr_i                 = '0;
        data_i                 = '0;
        load_i                 = 1'b0;
        rsp_ready_i            = 1'b0;
        store_buffer_commit_i  = 1'b0;
        store_buffer_idx_commit_i = '0;
        store_buffer_discard_i = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        req_valid_i = 1'b1;
        addr_i      = a;
        data_i      = d;
        step();
        req_valid_i = 1'b0;
        addr_i      = '0;
        data_i      = '0;
    endtask

    task automatic commit(input logic [IDX_W-1:0] idx);
        store_buffer_commit_i     = 1'b1;
        store_buffer_idx_commit_i = idx;
        step();
        store_buffer_commit_i     = 1'b0;
    endtask

    initial begin
        // Reset state, observed before any clock edge
        #2 rst_i = 1'b1;
        #1;
        check("rst_ready",   32'(req_ready_o), 32'h1);
        check("rst_rspv",    32'(rsp_valid_o), 32'h0);
        check("rst_idx",     32'(store_buffer_idx_o), 32'h0);
        check("rst_bypass",  32'(bypass_o), 32'h0);
        check("rst_addr_o",  addr_o, 32'h0);
        check("rst_data_wr", data_wr_o, 32'h0);
        step();
        rst_i = 1'b0;
        #1;

        // Single store, commit, write-out
        req_valid_i = 1'b1; addr_i = 32'h100; data_i = 32'hAA;
        #1;
        check("s1_idx", 32'(store_buffer_idx_o), 32'h0);
        step();
        idle();
        rsp_ready_i = 1'b1;
        #1;
        check("s1_spec_no_rsp", 32'(rsp_valid_o), 32'h0);
        commit(2'd0);
        check("s1_rspv", 32'(rsp_valid_o), 32'h1);
        check("s1_addr", addr_o, 32'h100);
        check("s1_data", data_wr_o, 32'hAA);
        step();
        check("s1_empty_rspv", 32'(rsp_valid_o), 32'h0);
        check("s1_empty_addr", addr_o, 32'h0);
        check("s1_tail_idx", 32'(store_buffer_idx_o), 32'h1);

        // Fill to full, pop one, reuse slot 0
        do_reset();
        for (int i = 0; i < SIZE; i++) begin
            req_valid_i = 1'b1; addr_i = 32'h300 + 32'(4 * i); data_i = 32'(i);
            #1;
            check($sformatf("fill_idx%0d", i), 32'(store_buffer_idx_o), 32'(i));
            check($sformatf("fill_ready%0d", i), 32'(req_ready_o), 32'h1);
            step();
        end
        idle();
        req_valid_i = 1'b1; addr_i = 32'h999; data_i = 32'h99;
        #1;
        check("full_ready", 32'(req_ready_o), 32'h0);
        step();
        idle();
        rsp_ready_i = 1'b1;
        commit(2'd0);
        check("full_head_rspv", 32'(rsp_valid_o), 32'h1);
        check("full_head_addr", addr_o, 32'h300);
        check("full_ready_pop", 32'(req_ready_o), 32'h0);
        step();
        check("after_pop_ready", 32'(req_ready_o), 32'h1);
        check("after_pop_idx", 32'(store_buffer_idx_o), 32'h0);

        // Forwarding: youngest match wins, same-cycle store invisible
        do_reset();
        store(32'h200, 32'h11);
        store(32'h200, 32'h22);
        load_i = 1'b1; addr_i = 32'h200;
        #1;
        check("fwd_bypass", 32'(bypass_o), EXP_BYP);
        check("fwd_data", data_rd_o, EXP_FWD);
        addr_i = 32'h204;
        #1;
        check("miss_bypass", 32'(bypass_o), 32'h0);
        check("miss_data", data_rd_o, 32'h0);
        req_valid_i = 1'b1; addr_i = 32'h300; data_i = 32'h33;
        #1;
        check("samecyc_bypass", 32'(bypass_o), 32'h0);
        step();
        idle();

        // Discard drains without a write; head advance proven by capacity
        do_reset();
        store(32'h500, 32'h55);
        store_buffer_discard_i = 4'b0001;
        step();
        idle();
        check("disc_rspv", 32'(rsp_valid_o), 32'h0);
        step();
        for (int i = 0; i < SIZE; i++) begin
            store(32'h510 + 32'(i), 32'(i));
            check($sformatf("disc_ready%0d", i), 32'(req_ready_o), (i == SIZE - 1) ? 32'h0 : 32'h1);
        end

        // Commit and discard on the same slot: discard wins
        do_reset();
        store(32'h580, 32'h58);
        rsp_ready_i = 1'b1;
        store_buffer_discard_i = 4'b0001;
        commit(2'd0);
        store_buffer_discard_i = '0;
        check("cd_rspv", 32'(rsp_valid_o), 32'h0);
        idle();

        // Backpressure: held stable for 3 cycles, accepted on the 4th
        do_reset();
        store(32'h600, 32'h66);
        commit(2'd0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("hold_rspv%0d", c), 32'(rsp_valid_o), 32'h1);
            check($sformatf("hold_addr%0d", c), addr_o, 32'h600);
            check($sformatf("hold_data%0d", c), data_wr_o, 32'h66);
            step();
        end
        rsp_ready_i = 1'b1;
        #1;
        check("accept_rspv", 32'(rsp_valid_o), 32'h1);
        step();
        check("accepted_rspv", 32'(rsp_valid_o), 32'h0);
        idle();

        // Asynchronous reset with two committed stores pending
        do_reset();
        store(32'h700, 32'h77);
        store(32'h704, 32'h78);
        commit(2'd0);
        commit(2'd1);
        check("pre_rst_rspv", 32'(rsp_valid_o), 32'h1);
        rst_i = 1'b1;
        #1;
        check("arst_rspv", 32'(rsp_valid_o), 32'h0);
        check("arst_ready", 32'(req_ready_o), 32'h1);
        check("arst_idx", 32'(store_buffer_idx_o), 32'h0);
        check("arst_addr", addr_o, 32'h0);
        step();
        rst_i = 1'b0;
        #1;
        req_valid_i = 1'b1; addr_i = 32'h800; data_i = 32'h88;
        #1;
        check("post_rst_idx", 32'(store_buffer_idx_o), 32'h0);
        step();
        idle();
        #1;
        check("post_rst_tail", 32'(store_buffer_idx_o), 32'h1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
